silife_ws2812: RTL
==================

# silife_ws2812

Serial LED-chain driver for the SiLife cell matrix. It scans the matrix one row at a time through the second read port (`row_select2`/`cells2`) and serialises every cell as a 24-bit GRB word in the WS2812 one-wire NRZ format. It sits beside the MAX7219 driver as a downstream consumer of the matrix scan port. The top level selects which driver owns that port.

## Interface

Parameters:
- `WIDTH`, 8, cells per row.
- `HEIGHT`, 8, rows.
- `T0H`, 20, clock cycles `o_dout` stays high for a 0 bit (400 ns at 50 MHz).
- `T1H`, 40, clock cycles high for a 1 bit.
- `TBIT`, 63, total clock cycles per bit; requires `TBIT > T1H > T0H ≥ 1`.
- `TLATCH`, 3000, clock cycles low after a frame (WS2812 latch/reset).

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  run continuous frames while high.
- `i_color`  in  24  GRB colour for live cells; dead cells send 24'h000000.
- `o_row_select`  out  $clog2(HEIGHT)  row address to the matrix scan port.
- `i_cells`  in  WIDTH  row contents; valid one cycle after `o_row_select` changes.
- `o_dout`  out  1  WS2812 data line.
- `o_busy`  out  1  high from frame start until the end of LATCH.
- `o_frame_done`  out  1  one-cycle pulse at the end of LATCH.

## Operation

- States: IDLE, LOAD, CAPTURE, HIGH, LOW, LATCH.
- **IDLE**
  - `o_dout`=0.
  - If `i_enable`=1: latch `i_color` into `color_q`, row=0, go to LOAD, set `o_busy`.
- **LOAD** (1 cycle): drive `o_row_select`=row.
- **CAPTURE** (1 cycle)
  - `row_buf <= i_cells`.
  - col=WIDTH-1, bit=23.
  - Go to HIGH.
- **Current bit**: `b = row_buf[col] ? color_q[bit] : 0`.
- **HIGH**
  - `o_dout`=1 for `b ? T1H : T0H` cycles.
  - Then go to LOW.
- **LOW**
  - `o_dout`=0 until the bit totals `TBIT` cycles.
  - Then advance. Bit counts 23→0; then col decrements; after col 0, row increments.
  - Next bit in the same row → HIGH.
  - Row finished and rows remain → LOAD.
  - Last row finished → LATCH.
- **LATCH**
  - `o_dout`=0 for `TLATCH` cycles.
  - Pulse `o_frame_done`.
  - If `i_enable`=1: restart the frame (re-latch `i_color`, row=0, LOAD).
  - Otherwise: IDLE, `o_busy`=0.
- **Ordering**
  - Rows go 0..HEIGHT-1.
  - Within a row, cells go MSB (col WIDTH-1) first, matching the matrix's left-to-right display order.
  - Colour bits go MSB first (G7 first).
- **`i_enable` deasserted mid-frame:** the current frame and latch complete; no truncated frame ever reaches the chain.
- **`i_color` changes mid-frame:** ignored until the next frame start.
- **Reset, at any time:**
  - `o_dout`=0, `o_row_select`=0, `o_busy`=0, `o_frame_done`=0.
  - State IDLE, all counters 0.
  - The chain sees a long low, which is a valid latch.
- **Width rules**
  - Timing counter is $clog2(max(TBIT,TLATCH)+1) bits.
  - Bit counter is 5 bits and wraps 0→23 on column advance.
  - Column and row counters are $clog2 of their dimension. Saturate, do not wrap, on the final compare.

## Timing

- First rising edge of `o_dout` comes 3 cycles after `i_enable` is sampled high in IDLE (IDLE→LOAD→CAPTURE→HIGH).
- Every bit lasts exactly `TBIT` cycles. Exception: the last bit of each row except the final row lasts `TBIT`+2, because LOAD and CAPTURE are inserted while the line is low. This stays well under the WS2812 latch threshold.
- Frame length in cycles: 1 + 2·HEIGHT + 24·WIDTH·HEIGHT·TBIT + TLATCH.
- All outputs are registered; no combinational path from inputs to `o_dout`.
- `o_frame_done` is high for exactly one cycle: the last LATCH cycle.

## Structure

- Shared package `silife_pkg`:
  - State enum `ws2812_state_t`.
  - Constant `WS2812_BITS_PER_PIXEL = 24`.
- Natural sub-module: `silife_ws2812_bit`.
  - Pure bit-timer with a start/bit/done handshake.
  - Owns the HIGH/LOW phase counter.
  - The parent FSM sequences rows, columns and colour bits.

## Test plan

Bench parameters: WIDTH=2, HEIGHT=2, T0H=2, T1H=4, TBIT=6, TLATCH=10.

- **Reset:** reset mid-HIGH → `o_dout`=0 immediately (asynchronously); after release, IDLE, `o_busy`=0, no pulse.
- **Single live cell:** cells row0=2'b10, row1=2'b00, `i_color`=24'h800001, `i_enable` for one frame.
  - Pixel 0 sends a high of 4 cycles, then 22 highs of 2, then a high of 4.
  - The other three pixels send 24 highs of 2 each.
  - The row-0→row-1 boundary bit lasts 8 cycles.
  - `o_frame_done` pulses once, then IDLE.
- **Scan port:** `o_row_select` reads 0 during frame start, 1 after the row-0 boundary, 0 again at the next frame; `i_cells` is sampled exactly one cycle after each change.
- **Enable drop:** deassert `i_enable` at bit 5 of pixel 1 → all 96 bits and the 10-cycle latch complete, `o_busy` falls with `o_frame_done`, no second frame.
- **Colour change:** change `i_color` from 24'hFFFFFF to 0 mid-frame with all cells live → current frame is all 1-bits, next frame is all 0-bits.
- **Continuous run:** hold `i_enable` → frame period is exactly 1+4+576+10=591 cycles, with back-to-back `o_frame_done` pulses 591 cycles apart.

Source files
------------

// File: rtl/silife_pkg.sv
// Shared definitions for the SiLife WS2812 chain driver.
//   ws2812_state_t        : driver FSM state encoding
//   WS2812_BITS_PER_PIXEL : GRB word length sent per cell
//   max_int               : constant helper for counter sizing
package silife_pkg;

  localparam int WS2812_BITS_PER_PIXEL = 24;

  typedef enum logic [2:0] {
    WS_IDLE    = 3'd0,
    WS_LOAD    = 3'd1,
    WS_CAPTURE = 3'd2,
    WS_HIGH    = 3'd3,
    WS_LOW     = 3'd4,
    WS_LATCH   = 3'd5
  } ws2812_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/silife_ws2812_if.sv
// Matrix scan port between the WS2812 driver and the cell matrix.
//   row_select : row address driven by the scanning driver
//   cells      : row contents returned by the matrix, one cycle after row_select
// master = scanning driver, slave = matrix.
interface silife_ws2812_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [RW-1:0]    row_select;
  logic [WIDTH-1:0] cells;

  modport master (output row_select, input cells);
  modport slave  (input row_select, output cells);
endinterface

// File: rtl/silife_ws2812_bit.sv
// WS2812 single-bit timer. A start pulse loads one bit; dout is high for
// T1H (bit_val=1) or T0H (bit_val=0) cycles and low for the rest of TBIT.
//   clk, reset_n : clock, async active-low reset
//   start        : begin a new bit on the next edge (may coincide with done)
//   bit_val      : value of the bit being started
//   dout         : registered line level
//   done         : high during the last cycle of the bit
module silife_ws2812_bit #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63,
  parameter int CW   = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic done
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] low_len;
  logic          active;

  assign done = active && (cnt == '0);

  // cnt counts the remaining cycles of the bit; the line stays high while the
  // remaining count is at least the length of the low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      low_len <= '0;
      active  <= 1'b0;
      dout    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      cnt     <= CW'(TBIT - 1);
      low_len <= bit_val ? CW'(TBIT - T1H) : CW'(TBIT - T0H);
      dout    <= 1'b1;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      dout <= (cnt - CW'(1)) >= low_len;
    end else begin
      active <= 1'b0;
      dout   <= 1'b0;
    end
  end

endmodule

// File: rtl/silife_ws2812.sv
// SiLife WS2812 LED-chain driver. Scans the cell matrix row by row and sends
// every cell as a 24-bit GRB word (live = i_color, dead = 0), MSB first.
//   clk, reset_n  : clock, async active-low reset
//   i_enable      : run continuous frames while high
//   i_color       : GRB colour for live cells, latched at frame start
//   scan          : matrix scan port (row_select out, cells in)
//   o_dout        : WS2812 data line
//   o_busy        : high from frame start to end of latch
//   o_frame_done  : one-cycle pulse on the last latch cycle
//
// state   | meaning
// IDLE    | line low, waiting for i_enable; latches colour on start
// LOAD    | row_select presented to the matrix
// CAPTURE | row captured, first bit of the row started
// HIGH    | high phase of the current bit
// LOW     | low phase of the current bit; advances bit/col/row at its end
// LATCH   | line held low TLATCH cycles, frame_done on the last one
module silife_ws2812
  import silife_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TLATCH = 3000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_enable,
  input  logic [23:0]            i_color,
  silife_ws2812_if.master        scan,
  output logic                   o_dout,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  localparam int CW = $clog2(max_int(TBIT, TLATCH) + 1);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [4:0] LAST_BIT = 5'(WS2812_BITS_PER_PIXEL - 1);

  localparam logic [2:0] S_IDLE    = 3'(WS_IDLE);
  localparam logic [2:0] S_LOAD    = 3'(WS_LOAD);
  localparam logic [2:0] S_CAPTURE = 3'(WS_CAPTURE);
  localparam logic [2:0] S_HIGH    = 3'(WS_HIGH);
  localparam logic [2:0] S_LOW     = 3'(WS_LOW);
  localparam logic [2:0] S_LATCH   = 3'(WS_LATCH);

  logic [2:0]       state;
  logic [23:0]      color_q;
  logic [WIDTH-1:0] row_buf;
  logic [RW-1:0]    row;
  logic [XW-1:0]    col;
  logic [4:0]       bit_idx;
  logic [CW-1:0]    lat_cnt;

  logic [XW-1:0]    col_nx;
  logic [4:0]       bit_nx;
  logic             row_end;
  logic             last_row;
  logic             bit_start;
  logic             bit_val;
  logic             bit_done;
  logic             bit_dout;

  // Indices of the bit following the current one within the row.
  always_comb begin
    col_nx = col;
    bit_nx = bit_idx - 5'd1;
    if (bit_idx == 5'd0) begin
      bit_nx = LAST_BIT;
      col_nx = col - XW'(1);
    end
  end

  assign row_end  = (bit_idx == 5'd0) && (col == '0);
  assign last_row = (row == RW'(HEIGHT - 1));

  // The next bit is started in the done cycle of the previous one so that
  // bits within a row follow each other with no gap. In CAPTURE the row is
  // not yet in row_buf, so the first bit comes straight from the scan port.
  always_comb begin
    bit_start = 1'b0;
    bit_val   = 1'b0;
    if (state == S_CAPTURE) begin
      bit_start = 1'b1;
      bit_val   = scan.cells[WIDTH-1] & color_q[LAST_BIT];
    end else if ((state == S_HIGH || state == S_LOW) && bit_done && !row_end) begin
      bit_start = 1'b1;
      bit_val   = row_buf[col_nx] & color_q[bit_nx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      color_q      <= '0;
      row_buf      <= '0;
      row          <= '0;
      col          <= '0;
      bit_idx      <= '0;
      lat_cnt      <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_busy <= i_enable;
          if (i_enable) begin
            color_q <= i_color;
            row     <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: state <= S_CAPTURE;
        S_CAPTURE: begin
          row_buf <= scan.cells;
          col     <= XW'(WIDTH - 1);
          bit_idx <= LAST_BIT;
          state   <= S_HIGH;
        end
        S_HIGH, S_LOW: begin
          if (bit_done) begin
            if (!row_end) begin
              col     <= col_nx;
              bit_idx <= bit_nx;
              state   <= S_HIGH;
            end else if (!last_row) begin
              row   <= row + RW'(1);
              state <= S_LOAD;
            end else begin
              lat_cnt      <= CW'(TLATCH - 1);
              o_frame_done <= (TLATCH == 1);
              state        <= S_LATCH;
            end
          end else if (state == S_HIGH && !bit_dout) begin
            state <= S_LOW;
          end
        end
        S_LATCH: begin
          if (lat_cnt == '0) begin
            // Stay busy through the restart cycle when running continuously.
            o_busy <= i_enable;
            state  <= S_IDLE;
          end else begin
            lat_cnt      <= lat_cnt - CW'(1);
            o_frame_done <= (lat_cnt == CW'(1));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign scan.row_select = row;
  assign o_dout          = bit_dout;

  silife_ws2812_bit #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT),
    .CW   (CW)
  ) u_bit (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bit_start),
    .bit_val (bit_val),
    .dout    (bit_dout),
    .done    (bit_done)
  );

endmodule
